// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state type and constants for the hazard detection unit
package hazard_pkg;
   typedef enum logic [1:0] {RUN = 2'd0, LOAD_STALL = 2'd1, MEM_WAIT = 2'd2} hazard_state_t;
   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam int WAIT_CNT_W = 16;
endpackage

// File: rtl/hazard_detection_unit_if.sv
// hazard_detection_unit_if: pipeline-side signal bundle of the hazard detection unit
interface hazard_detection_unit_if;
   logic [4:0] ID_rs1, ID_rs2, EX_rd;
   logic ID_UsesRs1, ID_UsesRs2, EX_MemRead, EX_BranchTaken, DMEM_req, DMEM_ready;
   logic PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, StallAll, mem_timeout;
   modport master (
      output ID_rs1, ID_rs2, EX_rd, ID_UsesRs1, ID_UsesRs2, EX_MemRead, EX_BranchTaken, DMEM_req, DMEM_ready,
      input PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, StallAll, mem_timeout
   );
   modport slave (
      input ID_rs1, ID_rs2, EX_rd, ID_UsesRs1, ID_UsesRs2, EX_MemRead, EX_BranchTaken, DMEM_req, DMEM_ready,
      output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, StallAll, mem_timeout
   );
endinterface

// File: rtl/hazard_sat_counter.sv
// hazard_sat_counter: W-bit event counter that saturates at all-ones
module hazard_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);
   always_ff @(posedge clk)
      if (rst) count <= '0;
      else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: load-use bubbles, taken-branch squash and memory-wait freeze.
// Define HAZARD_PERF_CNT_EN to add saturating bubble/freeze/flush counters.
module hazard_detection_unit
   import hazard_pkg::*;
#(
   parameter int LOAD_BUBBLES = 2,
   parameter int MEM_TIMEOUT  = 255,
   parameter int CNT_W        = 32
) (
   input logic clk,
   input logic rst,
   hazard_detection_unit_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] load_stall_cnt,
   output logic [CNT_W-1:0] mem_wait_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);
   localparam logic [1:0] BUB_INIT = 2'(LOAD_BUBBLES - 1);
   hazard_state_t state, ret_state, eff_state;
   logic [1:0] bub_cnt;
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic load_use, mem_stall, bubble, flush;
   assign load_use = hz.EX_MemRead && hz.EX_rd != REG_ZERO &&
                     ((hz.ID_UsesRs1 && hz.ID_rs1 == hz.EX_rd) || (hz.ID_UsesRs2 && hz.ID_rs2 == hz.EX_rd));
   assign mem_stall = hz.DMEM_req && !hz.DMEM_ready;
   // The cycle that releases a freeze behaves exactly like the state it interrupted.
   assign eff_state = (state == MEM_WAIT) ? ret_state : state;
   assign flush = !rst && !mem_stall && hz.EX_BranchTaken;
   assign bubble = !rst && !mem_stall && !hz.EX_BranchTaken &&
                   (eff_state == LOAD_STALL || (eff_state == RUN && load_use));
   assign hz.StallAll = !rst && mem_stall;
   assign hz.PCWrite = !rst && !mem_stall && !bubble;
   assign hz.IF_ID_Write = hz.PCWrite;
   assign hz.IF_ID_Flush = rst || flush;
   assign hz.ID_EX_Flush = rst || flush || bubble;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         ret_state <= RUN;
         bub_cnt <= '0;
         wait_cnt <= '0;
         hz.mem_timeout <= 1'b0;
      end else if (mem_stall) begin
         if (state != MEM_WAIT) begin
            state <= MEM_WAIT;
            ret_state <= state;
            wait_cnt <= WAIT_CNT_W'(1);
         end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (state == MEM_WAIT && wait_cnt == WAIT_CNT_W'(MEM_TIMEOUT)) hz.mem_timeout <= 1'b1;
      end else if (hz.EX_BranchTaken) begin
         state <= RUN;
         bub_cnt <= '0;
      end else if (eff_state == LOAD_STALL) begin
         state <= (bub_cnt == 2'd1) ? RUN : LOAD_STALL;
         bub_cnt <= bub_cnt - 1'b1;
      end else if (load_use && LOAD_BUBBLES > 1) begin
         state <= LOAD_STALL;
         bub_cnt <= BUB_INIT;
      end else begin
         state <= RUN;
      end
   end
`ifdef HAZARD_PERF_CNT_EN
   hazard_sat_counter #(.W(CNT_W)) u_load_cnt (.clk(clk), .rst(rst), .inc(bubble), .count(load_stall_cnt));
   hazard_sat_counter #(.W(CNT_W)) u_mem_cnt (.clk(clk), .rst(rst), .inc(hz.StallAll), .count(mem_wait_cnt));
   hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc(flush), .count(flush_cnt));
`else
`endif
endmodule
